// File: rtl/axi_feature_rd_master.sv
// AXI4 read master for per-line feature fetches: splits a request into bursts that
// respect MAX_BURST, the 4 KB boundary and an outstanding-burst limit.
module axi_feature_rd_master #(
    parameter int AXIWIDTH  = 128,
    parameter int LITEWIDTH = 32,
    parameter int LENWIDTH  = 16,
    parameter int MAX_BURST = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_rd_req,
    input  logic [LITEWIDTH-1:0] I_rd_addr,
    input  logic [LENWIDTH-1:0]  I_rd_beats,
    output logic [LITEWIDTH-1:0] O_araddr,
    output logic [7:0]           O_arlen,
    output logic                 O_arvalid,
    input  logic                 I_arready,
    input  logic [AXIWIDTH-1:0]  I_rdata,
    input  logic [1:0]           I_rresp,
    input  logic                 I_rlast,
    input  logic                 I_rvalid,
    output logic                 O_rready,
    output logic [AXIWIDTH-1:0]  O_feature,
    output logic                 O_feature_dv,
    output logic                 O_busy,
    output logic                 O_done,
    output logic                 O_req_drop,
    output logic                 O_rresp_err
);

    localparam int BPB = AXIWIDTH / 8;
    localparam int BSH = $clog2(BPB);
    localparam int OW  = $clog2(MAX_OUTST + 1);
    localparam int CW  = (LENWIDTH > 13) ? LENWIDTH : 13;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t               state, state_nx;
    logic [LITEWIDTH-1:0] ar_addr;
    logic [LENWIDTH-1:0]  ar_remain;
    logic [LENWIDTH-1:0]  total;
    logic [LENWIDTH-1:0]  r_recv;
    logic [OW-1:0]        outstanding;
    logic [12:0]          page_bytes;
    logic [CW-1:0]        page_beats;
    logic [CW-1:0]        burst_len;
    logic                 busy, accept, ar_ok, ar_hs, r_hs, last_hs;

    assign busy    = (state != IDLE);
    assign accept  = (state == IDLE) && I_rd_req && (I_rd_beats != '0);
    assign ar_ok   = (state == ISSUE) && (ar_remain != '0) && (outstanding < OW'(MAX_OUTST));
    assign ar_hs   = ar_ok && I_arready;
    assign r_hs    = I_rvalid && busy;
    assign last_hs = r_hs && I_rlast;

    // Beats left before the next 4 KB page; the address is always beat aligned.
    assign page_bytes = 13'h1000 - {1'b0, ar_addr[11:0]};
    assign page_beats = CW'(page_bytes >> BSH);

    always_comb begin
        burst_len = CW'(ar_remain);
        if (burst_len > CW'(MAX_BURST))
            burst_len = CW'(MAX_BURST);
        if (burst_len > page_beats)
            burst_len = page_beats;
    end

    // AR fields only change on a handshake, so they stay stable while stalled.
    assign O_arvalid = ar_ok;
    assign O_araddr  = ar_ok ? ar_addr : '0;
    assign O_arlen   = ar_ok ? 8'(burst_len - CW'(1)) : 8'd0;
    assign O_rready  = busy;
    assign O_busy    = busy;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   if (ar_remain == '0) state_nx = DRAIN;
            DRAIN:   if (r_recv == total) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            ar_addr      <= '0;
            ar_remain    <= '0;
            total        <= '0;
            r_recv       <= '0;
            outstanding  <= '0;
            O_feature    <= '0;
            O_feature_dv <= 1'b0;
            O_done       <= 1'b0;
            O_req_drop   <= 1'b0;
            O_rresp_err  <= 1'b0;
        end else begin
            O_feature_dv <= r_hs;
            O_done       <= ((state == IDLE) && I_rd_req && (I_rd_beats == '0)) ||
                            ((state == DRAIN) && (r_recv == total));
            O_req_drop   <= busy && I_rd_req;
            if (r_hs)
                O_feature <= I_rdata;
            if (accept) begin
                ar_addr     <= {I_rd_addr[LITEWIDTH-1:BSH], {BSH{1'b0}}};
                ar_remain   <= I_rd_beats;
                total       <= I_rd_beats;
                r_recv      <= '0;
                outstanding <= '0;
                O_rresp_err <= 1'b0;
            end else begin
                if (ar_hs) begin
                    ar_addr   <= ar_addr + (LITEWIDTH'(burst_len) << BSH);
                    ar_remain <= ar_remain - LENWIDTH'(burst_len);
                end
                if (r_hs)
                    r_recv <= r_recv + LENWIDTH'(1);
                if (r_hs && (I_rresp != 2'b00))
                    O_rresp_err <= 1'b1;
                // A burst issued and a burst retired in one cycle cancel out.
                case ({ar_hs, last_hs})
                    2'b10:   outstanding <= outstanding + OW'(1);
                    2'b01:   outstanding <= outstanding - OW'(1);
                    default: outstanding <= outstanding;
                endcase
            end
        end
    end

endmodule

// File: doc/axi_feature_rd_master.md
Name: axi_feature_rd_master

Overview:
- Services the accelerator's per-line feature fetch request (read flag plus DRAM byte address) by issuing AXI4 read bursts to DRAM.
- Returns the R-channel data as the 128-bit feature stream with data-valid that feeds the input line buffer.
- Sits between the conv core's feature-address generator and the memory interconnect; it is the DRAM-side responder for the feature read request.

Parameters:
- AXIWIDTH, 128, AXI data width in bits; bytes per beat BPB = AXIWIDTH/8.
- LITEWIDTH, 32, address width.
- LENWIDTH, 16, width of the per-request beat count.
- MAX_BURST, 16, maximum beats per AR burst (1..256).
- MAX_OUTST, 4, maximum outstanding AR bursts.

Ports:
- I_clk  in  1  clock
- I_rst  in  1  reset, asynchronous, active-high
- I_rd_req  in  1  one-cycle request pulse
- I_rd_addr  in  LITEWIDTH  request start byte address; low log2(BPB) bits are ignored and forced to 0
- I_rd_beats  in  LENWIDTH  beats to fetch for this request
- O_araddr  out  LITEWIDTH  AR address
- O_arlen  out  8  AR burst length minus 1
- O_arvalid  out  1  AR valid
- I_arready  in  1  AR ready
- I_rdata  in  AXIWIDTH  R data
- I_rresp  in  2  R response
- I_rlast  in  1  R last
- I_rvalid  in  1  R valid
- O_rready  out  1  R ready
- O_feature  out  AXIWIDTH  fetched beat
- O_feature_dv  out  1  O_feature valid
- O_busy  out  1  request in progress
- O_done  out  1  one-cycle pulse, request complete
- O_req_drop  out  1  one-cycle pulse, request ignored because busy
- O_rresp_err  out  1  sticky, non-OKAY response seen

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0. Reset asserted mid-request abandons it; no O_done is produced.
- States:
  - IDLE:
    - I_rd_req with I_rd_beats>0 → latch address and count, clear O_rresp_err, go ISSUE.
    - I_rd_req with I_rd_beats==0 → O_done pulses the next cycle; no AR is issued; stay IDLE.
  - ISSUE: while ar_remain>0, issue bursts (see AR rules). When ar_remain==0 → DRAIN.
  - DRAIN: wait for r_recv==total beats → pulse O_done, go IDLE.
- O_busy=1 in ISSUE and DRAIN.
- I_rd_req while busy → ignored; O_req_drop pulses the next cycle; the in-flight request is unaffected.
- AR rules:
  - Burst length len = min(ar_remain, MAX_BURST, (4096 - addr[11:0])/BPB). No burst crosses a 4 KB boundary.
  - O_arvalid is asserted only when outstanding<MAX_OUTST.
  - O_araddr and O_arlen hold stable while O_arvalid=1 and I_arready=0 (AXI rule). O_arvalid is never withdrawn before the handshake.
  - On handshake: addr += len*BPB; ar_remain -= len; outstanding += 1.
  - Back-to-back bursts are allowed; the next O_arvalid may follow a handshake with no idle cycle.
- R rules:
  - O_rready = O_busy. The downstream buffer has no backpressure.
  - On each rvalid&rready: O_feature <= I_rdata and O_feature_dv <= 1 in the next cycle (1-cycle latency), and r_recv += 1.
  - O_feature_dv is 0 otherwise; O_feature holds its last value.
  - rvalid&rready&rlast → outstanding -= 1.
  - AR handshake and last-beat handshake in the same cycle → outstanding unchanged.
  - I_rresp != 0 on any accepted beat → O_rresp_err = 1. The data is still forwarded and counted.
  - R beats arriving while in IDLE are not accepted (rready=0).
- O_done timing: asserted in the same cycle as the O_feature_dv of the final beat + 1, i.e. one cycle after the last dv.
- Widths: beat counters are LENWIDTH; the outstanding counter is clog2(MAX_OUTST+1) bits; the address adder wraps modulo 2^LITEWIDTH.

Test Plan:
- Basic split: req addr=0x1000, beats=40, arready=1, rvalid always → AR bursts (0x1000, len 15), (0x1100, 15), (0x1200, 7); 40 dv beats in order; O_done one cycle after the 40th dv.
- 4 KB crossing: addr=0x1FC0, beats=10 → AR (0x1FC0, arlen 3), then (0x2000, arlen 5); 10 beats returned.
- Outstanding limit: beats=96, arready=1, rvalid held 0 → exactly 4 ARs issued and arvalid stalls; release rvalid → remaining 2 ARs issue; total 96 dv.
- AR stall: arready=0 for 5 cycles → araddr/arlen stable and arvalid held; handshake on cycle 6.
- Drop and zero-length cases:
  - Second req while busy → O_req_drop pulse; the first request completes with the correct count.
  - beats=0 → O_done next cycle and no arvalid.
- Error and reset cases:
  - rresp=2 on beat 5 of 20 → O_rresp_err goes high and stays high; 20 dv beats still produced.
  - I_rst mid-DRAIN → all outputs 0 and no O_done.
